paddle_input_conditioner: RTL and testbench

Conditions the four raw Pong paddle controls (left up/down, right up/down) before they reach the pixel generator. Each control is synchronized and debounced. Each side is then reduced to one direction and speed command, sampled once per video frame, so paddle motion is frame-locked and grows faster while a control is held. The block sits between the board pins and the pixel generator's paddle inputs, in the same clock domain as the VGA sync generator.

---
 rtl/paddle_input_conditioner.sv | 135 +++++++++++++
 tb/tb_paddle_input_conditioner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_conditioner.sv
// Pong paddle control conditioning: per-channel 2-flop sync + debounce, then per-side
// frame-locked direction/speed commands that accelerate while a direction is held.
module paddle_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ACCEL_FRAMES    = 8,
    parameter int unsigned MAX_SPEED       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_in,
    input  logic       frame_tick,
    output logic [3:0] db_level,
    output logic [3:0] press,
    output logic [1:0] left_dir,
    output logic [2:0] left_speed,
    output logic [1:0] right_dir,
    output logic [2:0] right_speed,
    output logic       move_valid
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(ACCEL_FRAMES * MAX_SPEED + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(ACCEL_FRAMES * (MAX_SPEED - 1));

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         stable_q, stable_d;
    logic [3:0]         stable_dly_q, stable_dly_d;
    logic [3:0]         press_q, press_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;

    logic [1:0][1:0]    dir_q, dir_d;
    logic [1:0][2:0]    speed_q, speed_d;
    logic [1:0][HW-1:0] hold_q, hold_d;
    logic               move_valid_q, move_valid_d;
    logic [1:0][1:0]    new_dir;
    logic [1:0][31:0]   quot;

    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        stable_dly_d = stable_q;
        // Registered so the pulse lands one cycle after db_level rises
        press_d      = stable_q & ~stable_dly_q;
    end

    always_comb begin
        dir_d        = dir_q;
        speed_d      = speed_q;
        hold_d       = hold_q;
        move_valid_d = frame_tick;
        new_dir      = '0;
        quot         = '0;
        for (int s = 0; s < 2; s++) begin
            if (frame_tick) begin
                if (stable_q[2*s] && !stable_q[2*s+1]) begin
                    new_dir[s] = DIR_UP;
                end else if (!stable_q[2*s] && stable_q[2*s+1]) begin
                    new_dir[s] = DIR_DOWN;
                end else begin
                    new_dir[s] = DIR_HOLD;
                end

                // new_dir is non-hold here, so a match implies the old dir was non-hold too
                if (new_dir[s] != DIR_HOLD && new_dir[s] == dir_q[s]) begin
                    hold_d[s] = (hold_q[s] < HOLD_SAT) ? hold_q[s] + HW'(1) : hold_q[s];
                end else begin
                    hold_d[s] = '0;
                end

                quot[s] = 32'(hold_d[s]) / ACCEL_FRAMES;
                if (new_dir[s] == DIR_HOLD) begin
                    speed_d[s] = 3'd0;
                end else if (quot[s] + 32'd1 >= MAX_SPEED) begin
                    speed_d[s] = 3'(MAX_SPEED);
                end else begin
                    speed_d[s] = 3'(quot[s] + 32'd1);
                end
                dir_d[s] = new_dir[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            cnt_q        <= '0;
            dir_q        <= '0;
            speed_q      <= '0;
            hold_q       <= '0;
            move_valid_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            speed_q      <= speed_d;
            hold_q       <= hold_d;
            move_valid_q <= move_valid_d;
        end
    end

    assign db_level    = stable_q;
    assign press       = press_q;
    assign left_dir    = dir_q[0];
    assign left_speed  = speed_q[0];
    assign right_dir   = dir_q[1];
    assign right_speed = speed_q[1];
    assign move_valid  = move_valid_q;

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench for paddle_input_conditioner: expected commands are queued at each frame_tick
// and popped when move_valid fires; debounce/press behaviour is checked inline per test.
module tb_paddle_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'b0000;
    logic       frame_tick = 1'b0;
    logic [3:0] db_level;
    logic [3:0] press;
    logic [1:0] left_dir;
    logic [2:0] left_speed;
    logic [1:0] right_dir;
    logic [2:0] right_speed;
    logic       move_valid;

    typedef struct {
        logic [9:0]  val;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [9:0]  cur_exp = '0;
    int unsigned cyc = 0;
    int          total = 0;
    int          passed = 0;

    paddle_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .ACCEL_FRAMES   (2),
        .MAX_SPEED      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .frame_tick (frame_tick),
        .db_level   (db_level),
        .press      (press),
        .left_dir   (left_dir),
        .left_speed (left_speed),
        .right_dir  (right_dir),
        .right_speed(right_speed),
        .move_valid (move_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] cmd(input logic [1:0] ld, input logic [2:0] ls,
                                       input logic [1:0] rd, input logic [2:0] rs);
        return {ld, ls, rd, rs};
    endfunction

    // One clock edge; afterwards retire any move_valid against the queue and confirm
    // the command outputs still hold the last accepted command.
    task automatic step();
        logic       r;
        exp_t       e;
        logic [9:0] outs;
        @(posedge clk);
        r = rst;
        #1;
        cyc++;
        if (r) begin
            cur_exp = '0;
            sb.delete();
        end
        if (move_valid) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL move_valid_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc !== cyc) begin
                    $display("FAIL move_valid_cycle: got cycle %0d, required %0d", cyc, e.cyc);
                end else begin
                    passed++;
                end
                cur_exp = e.val;
            end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            total++;
            e = sb.pop_front();
            $display("FAIL move_valid_missing: no pulse at cycle %0d, required one", cyc);
            cur_exp = e.val;
        end
        outs = {left_dir, left_speed, right_dir, right_speed};
        total++;
        if (outs !== cur_exp) begin
            $display("FAIL cmd_outputs cycle %0d: got %b, required %b", cyc, outs, cur_exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick(input logic [9:0] exp_val);
        exp_t e;
        frame_tick = 1'b1;
        e.val = exp_val;
        e.cyc = cyc + 1;
        sb.push_back(e);
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        raw_in = 4'b1111;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (db_level !== 4'b0 || press !== 4'b0 || move_valid !== 1'b0) begin
                $display("FAIL reset_outputs: got db=%b press=%b mv=%b, required 0",
                         db_level, press, move_valid);
            end else begin
                passed++;
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (db_level !== ((i >= 6) ? 4'b1111 : 4'b0000)) begin
                $display("FAIL reset_db edge %0d: got %b", i, db_level);
            end else begin
                passed++;
            end
            total++;
            if (press !== ((i == 7) ? 4'b1111 : 4'b0000)) begin
                $display("FAIL reset_press edge %0d: got %b", i, press);
            end else begin
                passed++;
            end
        end
        raw_in = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (press !== 4'b0000 || db_level !== ((i >= 6) ? 4'b0000 : 4'b1111)) begin
                $display("FAIL release edge %0d: got db=%b press=%b", i, db_level, press);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_glitch();
        raw_in = 4'b0001;
        for (int i = 0; i < 3; i++) step();
        raw_in = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (db_level !== 4'b0000 || press !== 4'b0000) begin
                $display("FAIL glitch_reject: got db=%b press=%b, required 0000/0000",
                         db_level, press);
            end else begin
                passed++;
            end
        end
        raw_in = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if (db_level !== ((i >= 6) ? 4'b0001 : 4'b0000)) begin
                $display("FAIL glitch_accept edge %0d: got %b", i, db_level);
            end else begin
                passed++;
            end
            total++;
            if (press !== ((i == 7) ? 4'b0001 : 4'b0000)) begin
                $display("FAIL glitch_press edge %0d: got %b", i, press);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_accel();
        logic [2:0] spd [6];
        spd = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
        for (int i = 0; i < 6; i++) begin
            tick(cmd(2'b01, spd[i], 2'b00, 3'd0));
            step();
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) tick(cmd(2'b01, 3'd3, 2'b00, 3'd0));
        step();
    endtask

    task automatic test_conflict();
        raw_in = 4'b0011;
        // db_level[1] rises on the same edge that samples this tick: old level applies
        for (int i = 0; i < 5; i++) step();
        tick(cmd(2'b01, 3'd3, 2'b00, 3'd0));
        step();
        tick(cmd(2'b00, 3'd0, 2'b00, 3'd0));
        raw_in = 4'b0010;
        for (int i = 0; i < 7; i++) step();
        tick(cmd(2'b10, 3'd1, 2'b00, 3'd0));
        tick(cmd(2'b10, 3'd1, 2'b00, 3'd0));
        tick(cmd(2'b10, 3'd2, 2'b00, 3'd0));
        raw_in = 4'b0001;
        for (int i = 0; i < 7; i++) step();
        tick(cmd(2'b01, 3'd1, 2'b00, 3'd0));
        step();
    endtask

    task automatic test_reset_mid();
        logic [2:0] spd [5];
        spd = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
        raw_in = 4'b1000;
        for (int i = 0; i < 7; i++) step();
        for (int i = 0; i < 5; i++) begin
            tick(cmd(2'b00, 3'd0, 2'b10, spd[i]));
            step();
        end
        rst        = 1'b1;
        frame_tick = 1'b1;
        step();
        rst        = 1'b0;
        frame_tick = 1'b0;
        total++;
        if (db_level !== 4'b0000 || move_valid !== 1'b0) begin
            $display("FAIL reset_mid: got db=%b mv=%b, required 0000/0", db_level, move_valid);
        end else begin
            passed++;
        end
        step();
        tick(cmd(2'b00, 3'd0, 2'b00, 3'd0));
        for (int i = 0; i < 6; i++) step();
        total++;
        if (db_level !== 4'b1000) begin
            $display("FAIL reaccept_db: got %b, required 1000", db_level);
        end else begin
            passed++;
        end
        tick(cmd(2'b00, 3'd0, 2'b10, 3'd1));
        tick(cmd(2'b00, 3'd0, 2'b10, 3'd1));
        step();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_accel();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        for (int i = 0; i < 3; i++) step();
        total++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d commands outstanding, required 0", sb.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
